// File: rtl/mmio_pkg.sv
// Shared register map, STATUS bit positions and FSM encoding for the MMIO UART transmitter.
// No logic here. Nothing to backpressure.
package mmio_pkg;

  localparam logic [3:0] DATA_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] DIV_OFS    = 4'h8;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_PARITY = 4;
  localparam int STAT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // A divisor of zero would give a bit with no duration, so it is clamped to one.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Circular FIFO with extra-MSB pointers; dout shows the head entry combinationally.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty/full come only from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter (even parity bit added when MMIO_UART_PARITY_EN is defined).
// Latency: start bit appears on tx two cycles after the DATA store; frame = 10 (11) * divisor cycles.
// Backpressure: none on the bus; stores to a full FIFO are dropped and flagged as sticky overflow.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        tx_idle
);

`ifdef MMIO_UART_PARITY_EN
  localparam logic        PARITY_PRESENT = 1'b1;
  localparam uart_state_e AFTER_DATA     = ST_PARITY;
`else
  localparam logic        PARITY_PRESENT = 1'b0;
  localparam uart_state_e AFTER_DATA     = ST_STOP;
`endif

  logic        hit, wr_data, wr_div, rd_status;
  logic [3:0]  ofs;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic [STAT_W-1:0] status;
  uart_state_e state_q, state_d;
`ifdef MMIO_UART_PARITY_EN
  logic        par_q, par_d;
`endif
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^mem_wdata[31:16];

  assign hit       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs       = mem_addr[3:0];
  assign wr_data   = mem_wr && hit && (ofs == DATA_OFS);
  assign wr_div    = mem_wr && hit && (ofs == DIV_OFS);
  assign rd_status = mem_rd && hit && (ofs == STATUS_OFS);
  assign fifo_push = wr_data && (!fifo_full || fifo_pop);

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fifo_inst (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = (state_q != ST_IDLE);
    status[STAT_FULL]    = fifo_full;
    status[STAT_EMPTY]   = fifo_empty;
    status[STAT_OVF]     = ovf_q;
    status[STAT_PARITY]  = PARITY_PRESENT;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_rd && hit) begin
      case (ofs)
        STATUS_OFS: mem_rdata = {{(32-STAT_W){1'b0}}, status};
        DIV_OFS:    mem_rdata = {16'b0, div_q};
        default:    mem_rdata = '0;
      endcase
    end
  end

  // A dropped store in the same cycle as the clearing read keeps overflow set.
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = clamp_div(mem_wdata[15:0]);
    if (rd_status) ovf_d = 1'b0;
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
`ifdef MMIO_UART_PARITY_EN
    par_d    = par_q;
`endif
    bit_end  = (cnt_q == 16'd0);
    if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
`ifdef MMIO_UART_PARITY_EN
          par_d    = ^fifo_dout;
`endif
          cnt_d    = div_q - 16'd1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          cnt_d   = div_q - 16'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = AFTER_DATA;
          else               bit_d   = bit_q + 3'd1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          cnt_d   = div_q - 16'd1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
`ifdef MMIO_UART_PARITY_EN
            par_d    = ^fifo_dout;
`endif
            cnt_d    = div_q - 16'd1;
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_idle = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus decode, framing, FIFO overflow, chaining and async reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_FF00;
`ifdef MMIO_UART_PARITY_EN
  localparam int          NB  = 11;
  localparam logic [31:0] PAR = 32'h10;
`else
  localparam int          NB  = 10;
  localparam logic [31:0] PAR = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        tx, tx_idle;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .tx_idle   (tx_idle)
  );

  // Bus helpers are called at a falling edge and return at the next falling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_addr = addr; mem_wdata = data; mem_wr = 1'b1;
    @(negedge clk);
    mem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    mem_addr = addr; mem_rd = 1'b1;
    #1 data = mem_rdata;
    @(negedge clk);
    mem_rd = 1'b0;
  endtask

  // Expected line level after clock edge j, where edge 0 captured the first DATA store.
  function automatic logic exp_tx(input logic [7:0] b0, input logic [7:0] b1,
                                  input int nbytes, input int j, input int div);
    int k, f, b;
    logic [7:0] by;
    if (j < 2) return 1'b1;
    k = (j - 2) / div;
    f = k / NB;
    b = k % NB;
    if (f >= nbytes) return 1'b1;
    by = (f == 0) ? b0 : b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (NB == 11 && b == 9) return ^by;
    return 1'b1;
  endfunction

  task automatic run_frames(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input int nbytes, input int div, input int start_j);
    int bad_tx = 0, bad_idle = 0, first_tx = -1, first_idle = -1;
    int last = 1 + nbytes * NB * div;
    logic e;
    for (int j = start_j; j <= last + 3; j++) begin
      if (j > start_j) @(negedge clk);
      e = exp_tx(b0, b1, nbytes, j, div);
      if (tx !== e) begin bad_tx++; if (first_tx < 0) first_tx = j; end
      if (tx_idle !== (j >= last)) begin bad_idle++; if (first_idle < 0) first_idle = j; end
    end
    n_checks++;
    if (bad_tx != 0) $display("FAIL %s_tx: %0d wrong cycles (first at cycle %0d), required 0", name, bad_tx, first_tx);
    else n_pass++;
    n_checks++;
    if (bad_idle != 0) $display("FAIL %s_idle: %0d wrong cycles (first at cycle %0d), required 0", name, bad_idle, first_idle);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b need 1", tx); else n_pass++;
    n_checks++; if (tx_idle !== 1'b1) $display("FAIL reset_idle: got %b need 1", tx_idle); else n_pass++;
    n_checks++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h need 0", mem_rdata); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== (32'h4 | PAR)) $display("FAIL reset_status: got %h need %h", d, 32'h4 | PAR); else n_pass++;
    bus_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'd16) $display("FAIL reset_div: got %h need %h", d, 32'd16); else n_pass++;
  endtask

  task automatic test_decode;
    logic [31:0] d;
    bus_read(BASE + 32'hC, d);
    n_checks++; if (d !== 32'h0) $display("FAIL rd_ofs_c: got %h need 0", d); else n_pass++;
    bus_read(BASE, d);
    n_checks++; if (d !== 32'h0) $display("FAIL rd_data: got %h need 0", d); else n_pass++;
    bus_read(BASE + 32'h108, d);
    n_checks++; if (d !== 32'h0) $display("FAIL rd_miss: got %h need 0", d); else n_pass++;
    mem_addr = BASE + 32'h8; #1;
    n_checks++; if (mem_rdata !== 32'h0) $display("FAIL rd_no_strobe: got %h need 0", mem_rdata); else n_pass++;
    @(negedge clk);
    bus_write(BASE + 32'h10, 32'h41);
    bus_write(BASE + 32'hC, 32'h5);
    repeat (3) @(negedge clk);
    n_checks++; if (tx_idle !== 1'b1 || tx !== 1'b1) $display("FAIL wr_miss_idle: got idle=%b tx=%b need 1 1", tx_idle, tx); else n_pass++;
    bus_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'd16) $display("FAIL wr_ofs_c_div: got %h need %h", d, 32'd16); else n_pass++;
    mem_addr = BASE + 32'h8; mem_wdata = 32'h3; mem_wr = 1'b1; mem_rd = 1'b1;
    #1 d = mem_rdata;
    @(negedge clk);
    mem_wr = 1'b0; mem_rd = 1'b0;
    n_checks++; if (d !== 32'd16) $display("FAIL rdwr_same_old: got %h need %h", d, 32'd16); else n_pass++;
    bus_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'd3) $display("FAIL rdwr_same_new: got %h need %h", d, 32'd3); else n_pass++;
    bus_write(BASE + 32'h8, 32'd16);
  endtask

  task automatic test_frame_55;
    bus_write(BASE, 32'h55);
    run_frames("frame_55", 8'h55, 8'h00, 1, 16, 0);
  endtask

  task automatic test_div_zero;
    logic [31:0] d;
    bus_write(BASE + 32'h8, 32'h0);
    bus_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'd1) $display("FAIL div_zero_read: got %h need 1", d); else n_pass++;
    bus_write(BASE, 32'hA3);
    run_frames("frame_a3_div1", 8'hA3, 8'h00, 1, 1, 0);
  endtask

  task automatic test_back_to_back;
    bus_write(BASE + 32'h8, 32'd2);
    bus_write(BASE, 32'h01);
    bus_write(BASE, 32'h80);
    run_frames("b2b_01_80", 8'h01, 8'h80, 2, 2, 1);
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int waited = 0;
    bus_write(BASE + 32'h8, 32'd16);
    for (int i = 0; i < 6; i++) bus_write(BASE, 32'h10 + i);
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== (32'hB | PAR)) $display("FAIL ovf_status: got %h need %h", d, 32'hB | PAR); else n_pass++;
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== (32'h3 | PAR)) $display("FAIL ovf_cleared: got %h need %h", d, 32'h3 | PAR); else n_pass++;
    while (!tx_idle && waited < 3000) begin @(negedge clk); waited++; end
    // Five frames from the first store end at edge 1+5*NB*16; we sit at edge 7 here.
    n_checks++; if (waited != 5 * NB * 16 - 6) $display("FAIL ovf_drain_cycles: got %0d need %0d", waited, 5 * NB * 16 - 6); else n_pass++;
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== (32'h4 | PAR)) $display("FAIL ovf_final_status: got %h need %h", d, 32'h4 | PAR); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int bad = 0;
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h00);
    repeat (69) @(negedge clk);
    n_checks++; if (tx !== 1'b0) $display("FAIL mid_bit3_low: got %b need 0", tx); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b need 1", tx); else n_pass++;
    n_checks++; if (tx_idle !== 1'b1) $display("FAIL async_reset_idle: got %b need 1", tx_idle); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== (32'h4 | PAR)) $display("FAIL post_reset_status: got %h need %h", d, 32'h4 | PAR); else n_pass++;
    bus_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'd16) $display("FAIL post_reset_div: got %h need %h", d, 32'd16); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL post_reset_quiet: %0d active cycles, need 0", bad); else n_pass++;
  endtask

`ifdef MMIO_UART_PARITY_EN
  task automatic test_parity;
    logic [31:0] d;
    bus_write(BASE + 32'h8, 32'd2);
    bus_write(BASE, 32'h07);
    run_frames("parity_07", 8'h07, 8'h00, 1, 2, 0);
    bus_read(BASE + 32'h4, d);
    n_checks++; if (d !== 32'h14) $display("FAIL parity_status: got %h need %h", d, 32'h14); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_decode;
    test_frame_55;
    test_div_zero;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
`ifdef MMIO_UART_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
